// File: rtl/sequenciador_notas.sv
// Programmable melody sequencer driving the {N1,N2,N3,D} note interface from an internal RAM.
// Optional macro SEQ_GAP_EN: blank the last tick of every played note (articulation gap).
module sequenciador_notas #(
  parameter int TICKS_PER_BEAT = 4,
  parameter int SEQ_LEN        = 16,
  parameter int AW             = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [5:0]    wr_data,
  input  logic          start,
  input  logic          stop,
  input  logic          loop_en,
  output logic          N1,
  output logic          N2,
  output logic          N3,
  output logic          D,
  output logic          playing,
  output logic [AW-1:0] step_idx,
  output logic          done
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_PLAY = 1'b1;

  localparam int            TW        = (TICKS_PER_BEAT > 1) ? $clog2(TICKS_PER_BEAT) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BEAT - 1);
  localparam logic [AW-1:0] IDX_LAST  = AW'(SEQ_LEN - 1);

  // Entry layout: {note[2:0], D, dur[1:0]}
  function automatic logic is_marker(input logic [5:0] e);
    return (e[5:3] == 3'b000) && e[2];
  endfunction

  function automatic logic [3:0] entry_code(input logic [5:0] e);
    return (e[5:3] != 3'b000) ? e[5:2] : 4'b0000;
  endfunction

  logic [5:0]    mem [SEQ_LEN];
  logic [0:0]    state;
  logic [TW-1:0] tick;
  logic [1:0]    beat;
  logic [1:0]    cur_dur;
  logic [3:0]    out_code;
  logic          done_r;
  logic [AW-1:0] idx_r;

  logic [AW-1:0] next_idx;
  logic [5:0]    next_entry;
  logic [5:0]    first_play;
  logic          first_marker;
  logic          last_cycle;
  logic          wrap;
  logic          load_en;
  logic [AW-1:0] load_idx;
  logic [5:0]    load_e;
  logic          go_idle;
  logic          fire_done;

  always_ff @(posedge clk) begin
    if (wr_en && (state == S_IDLE)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // A marker at entry 0 under looping plays as a one-beat rest so the sequencer never spins in zero time.
  always_comb begin
    next_idx     = idx_r + 1'b1;
    next_entry   = mem[next_idx];
    first_marker = is_marker(mem[{AW{1'b0}}]);
    first_play   = first_marker ? 6'b000000 : mem[{AW{1'b0}}];
    last_cycle   = (tick == TICK_LAST) && (beat == cur_dur);
    wrap         = (idx_r == IDX_LAST) || is_marker(next_entry);
  end

  always_comb begin
    load_en   = 1'b0;
    load_idx  = '0;
    load_e    = '0;
    go_idle   = 1'b0;
    fire_done = 1'b0;
    if (state == S_IDLE) begin
      if (start && !stop) begin
        if (first_marker && !loop_en) begin
          fire_done = 1'b1;
        end else begin
          load_en = 1'b1;
          load_e  = first_play;
        end
      end
    end else if (stop) begin
      go_idle = 1'b1;
    end else if (last_cycle) begin
      if (!wrap) begin
        load_en  = 1'b1;
        load_idx = next_idx;
        load_e   = next_entry;
      end else if (loop_en) begin
        load_en = 1'b1;
        load_e  = first_play;
      end else begin
        go_idle   = 1'b1;
        fire_done = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      tick     <= '0;
      beat     <= '0;
      cur_dur  <= '0;
      out_code <= '0;
      idx_r    <= '0;
      done_r   <= 1'b0;
    end else begin
      done_r <= fire_done;
      if (load_en) begin
        state    <= S_PLAY;
        idx_r    <= load_idx;
        cur_dur  <= load_e[1:0];
        out_code <= entry_code(load_e);
        tick     <= '0;
        beat     <= '0;
      end else if (go_idle) begin
        state    <= S_IDLE;
        idx_r    <= '0;
        out_code <= '0;
        tick     <= '0;
        beat     <= '0;
      end else if (state == S_PLAY) begin
        if (tick == TICK_LAST) begin
          tick <= '0;
          beat <= beat + 1'b1;
        end else begin
          tick <= tick + 1'b1;
        end
`ifdef SEQ_GAP_EN
        // Rests already output zero, so blanking unconditionally only affects notes.
        if ((tick == TW'(TICKS_PER_BEAT - 2)) && (beat == cur_dur)) begin
          out_code <= '0;
        end
`endif
      end
    end
  end

  assign {N1, N2, N3, D} = out_code;
  assign playing         = (state == S_PLAY);
  assign step_idx        = idx_r;
  assign done            = done_r;

endmodule

// File: tb/tb_sequenciador_notas.sv
// Scoreboard bench for sequenciador_notas (TICKS_PER_BEAT=2, SEQ_LEN=8): stimulus queues
// per-cycle expected outputs, a negedge monitor pops and compares them.
module tb_sequenciador_notas;

`ifdef SEQ_GAP_EN
  localparam bit GAP = 1'b1;
`else
  localparam bit GAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [5:0] wr_data = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       loop_en = 1'b0;
  logic       N1, N2, N3, D, playing, done;
  logic [2:0] step_idx;

  sequenciador_notas #(.TICKS_PER_BEAT(2), .SEQ_LEN(8), .AW(3)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .stop(stop), .loop_en(loop_en),
    .N1(N1), .N2(N2), .N3(N3), .D(D), .playing(playing), .step_idx(step_idx), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    string      nm;
    logic [8:0] val;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t e_mon;
  logic [8:0] act;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every queued expectation whose cycle has arrived.
  always @(negedge clk) begin
    act = {N1, N2, N3, D, playing, step_idx, done};
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e_mon = q.pop_front();
      n_chk++;
      if (e_mon.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: not sampled at cycle %0d (now %0d)", e_mon.nm, e_mon.cyc, cyc);
      end else if (act !== e_mon.val) begin
        n_fail++;
        $display("FAIL %s @cycle %0d: {N,D,playing,idx,done} got %b required %b",
                 e_mon.nm, cyc, act, e_mon.val);
      end
    end
  end

  function automatic logic [8:0] pack(input logic [2:0] n, input logic d, input logic pl,
                                      input logic [2:0] idx, input logic dn);
    return {n, d, pl, idx, dn};
  endfunction

  task automatic push(input int c, input string nm, input logic [8:0] v);
    exp_t e;
    e.cyc = c;
    e.nm  = nm;
    e.val = v;
    q.push_back(e);
  endtask

  task automatic exp_note(input int c, input string nm, input logic [2:0] n, input logic d,
                          input logic [2:0] idx, input int len);
    for (int i = 0; i < len; i++) begin
      if (GAP && (i == len - 1) && (n != 3'b000)) push(c + i, nm, pack(3'b000, 1'b0, 1'b1, idx, 1'b0));
      else                                        push(c + i, nm, pack(n, d, 1'b1, idx, 1'b0));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [5:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cycle();
    wr_en = 1'b0;
  endtask

  task automatic start_play(output int s);
    start = 1'b1;
    cycle();
    start = 1'b0;
    s = cyc;
  endtask

  task automatic prog_a();
    wr(3'd0, 6'b001_0_00);
    wr(3'd1, 6'b011_1_01);
    wr(3'd2, 6'b000_1_00);
  endtask

  task automatic exp_melody_a(input int s, input string tag);
    exp_note(s,     {tag, "_n0"}, 3'b001, 1'b0, 3'd0, 2);
    exp_note(s + 2, {tag, "_n1"}, 3'b011, 1'b1, 3'd1, 4);
    push(s + 6, {tag, "_done"}, pack(3'b000, 1'b0, 1'b0, 3'd0, 1'b1));
    push(s + 7, {tag, "_idle"}, pack(3'b000, 1'b0, 1'b0, 3'd0, 1'b0));
  endtask

  initial begin
    int s;
    // Reset state
    repeat (2) cycle();
    push(cyc,     "reset0", 9'd0);
    push(cyc + 1, "reset1", 9'd0);
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();

    // Basic melody ending on a marker
    prog_a();
    start_play(s);
    exp_melody_a(s, "basic");
    repeat (8) cycle();

    // Looping melody; a start pulse mid-play must not restart it
    loop_en = 1'b1;
    start_play(s);
    exp_note(s,      "loop_a0", 3'b001, 1'b0, 3'd0, 2);
    exp_note(s + 2,  "loop_a1", 3'b011, 1'b1, 3'd1, 4);
    exp_note(s + 6,  "loop_b0", 3'b001, 1'b0, 3'd0, 2);
    exp_note(s + 8,  "loop_b1", 3'b011, 1'b1, 3'd1, 4);
    exp_note(s + 12, "loop_c0", 3'b001, 1'b0, 3'd0, 1);
    push(s + 13, "loop_stop", 9'd0);
    push(s + 14, "loop_idle", 9'd0);
    repeat (3) cycle();
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (8) cycle();
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    loop_en = 1'b0;
    repeat (3) cycle();

    // Write during PLAY is lost; stop beats a simultaneous start
    start_play(s);
    exp_note(s, "ws_n0", 3'b001, 1'b0, 3'd0, 2);
    push(s + 2, "ws_stop", 9'd0);
    push(s + 3, "ws_idle", 9'd0);
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 6'b111_1_00;
    cycle();
    wr_en = 1'b0; stop = 1'b1; start = 1'b1;
    cycle();
    stop = 1'b0; start = 1'b0;
    repeat (2) cycle();
    start_play(s);
    exp_melody_a(s, "replay");
    repeat (8) cycle();

    // Asynchronous reset mid-playback keeps the RAM
    start_play(s);
    exp_note(s,     "rst_n0", 3'b001, 1'b0, 3'd0, 2);
    exp_note(s + 2, "rst_n1", 3'b011, 1'b1, 3'd1, 1);
    push(s + 3, "rst_mid0", 9'd0);
    push(s + 4, "rst_mid1", 9'd0);
    repeat (3) cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
    start_play(s);
    exp_melody_a(s, "post_rst");
    repeat (8) cycle();

    // Rest entry between notes
    wr(3'd0, 6'b001_0_00);
    wr(3'd1, 6'b000_0_01);
    wr(3'd2, 6'b011_1_01);
    wr(3'd3, 6'b000_1_00);
    start_play(s);
    exp_note(s,     "rest_n0", 3'b001, 1'b0, 3'd0, 2);
    exp_note(s + 2, "rest_r1", 3'b000, 1'b0, 3'd1, 4);
    exp_note(s + 6, "rest_n2", 3'b011, 1'b1, 3'd2, 4);
    push(s + 10, "rest_done", pack(3'b000, 1'b0, 1'b0, 3'd0, 1'b1));
    push(s + 11, "rest_idle", 9'd0);
    repeat (12) cycle();

    // Full table without marker ends after index 7
    for (int i = 0; i < 8; i++) wr(3'(i), {3'((i % 7) + 1), i[0], 2'b00});
    start_play(s);
    for (int i = 0; i < 8; i++) exp_note(s + 2 * i, "full", 3'((i % 7) + 1), i[0], 3'(i), 2);
    push(s + 16, "full_done", pack(3'b000, 1'b0, 1'b0, 3'd0, 1'b1));
    push(s + 17, "full_idle", 9'd0);
    repeat (18) cycle();

    // Entry 0 is a marker: immediate done, or a one-beat rest when looping
    wr(3'd0, 6'b000_1_00);
    wr(3'd1, 6'b000_1_00);
    start_play(s);
    push(s,     "m0_done", pack(3'b000, 1'b0, 1'b0, 3'd0, 1'b1));
    push(s + 1, "m0_idle", 9'd0);
    repeat (2) cycle();
    loop_en = 1'b1;
    start_play(s);
    exp_note(s,     "m0_rest_a", 3'b000, 1'b0, 3'd0, 2);
    exp_note(s + 2, "m0_rest_b", 3'b000, 1'b0, 3'd0, 2);
    push(s + 4, "m0_stop", 9'd0);
    repeat (3) cycle();
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    loop_en = 1'b0;

    for (int i = 0; i < 20 && q.size() > 0; i++) cycle();
    if (q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations never reached, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
